// File: rtl/lvc_ahb_pkg.sv
// Shared AHB encodings, slave FSM states and lane-size helper for the SRAM slave.
// Combinational only, so it adds no latency and has no backpressure.
package lvc_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_state_e;

  // Unshifted byte-lane mask for a transfer size; sizes above a doubleword give no lanes.
  function automatic logic [7:0] lane_bits(input logic [2:0] size);
    case (size)
      SIZE_BYTE:  return 8'h01;
      SIZE_HALF:  return 8'h03;
      SIZE_WORD:  return 8'h0F;
      SIZE_DWORD: return 8'hFF;
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lvc_ahb_sram_mem.sv
// SRAM array with per-byte write enables, synchronous write and asynchronous read.
// Write lands on the clock edge and is visible to the read port right after it; never stalls.
module lvc_ahb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDXW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTES-1:0]      we,
  input  logic [IDXW-1:0]       idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/lvc_ahb_sram_slave.sv
// AHB slave in front of an SRAM: data phase lasts WAIT_STATES+1 cycles, errors take two.
// Stretches the data phase by driving hreadyout low; holds state while another slave stalls hready.
module lvc_ahb_sram_slave
  import lvc_ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * BYTES);

  ahb_slv_state_e        state;
  logic [3:0]            wcnt;
  logic                  wr_q;
  logic [IDXW-1:0]       idx_q;
  logic [BYTES-1:0]      be_q;

  logic                  accept;
  logic                  illegal;
  logic [OFFW-1:0]       align_mask;
  logic [15:0]           be_wide;
  logic [BYTES-1:0]      be;
  logic [BYTES-1:0]      mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_ok;

  always_comb begin
    accept     = hsel && hready && (htrans == NONSEQ || htrans == SEQ) &&
                 (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    align_mask = OFFW'((32'd1 << hsize) - 32'd1);
    illegal    = ({1'b0, haddr} >= MEM_BYTES) || (hsize > 3'(OFFW)) ||
                 ((haddr[OFFW-1:0] & align_mask) != '0);
    be_wide    = {8'h00, lane_bits(hsize)} << haddr[OFFW-1:0];
    be         = be_wide[BYTES-1:0];
    // A write lands on the edge that closes its data phase, so a pipelined read sees it.
    mem_we     = (state == ST_DATA && hready && wr_q) ? be_q : '0;
    hrdata     = (state == ST_DATA && !wr_q) ? mem_rdata : '0;
  end

  assign unused_ok = ^{hburst, hprot, be_wide};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      hreadyout <= 1'b1;
      hresp     <= OKAY;
      wcnt      <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= ST_DATA;
            hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
        end
        default: begin
          if (hready) begin
            if (accept) begin
              idx_q <= haddr[IDXW+OFFW-1:OFFW];
              be_q  <= be;
              wr_q  <= hwrite && !illegal;
              if (illegal) begin
                state     <= ST_ERR1;
                hreadyout <= 1'b0;
                hresp     <= ERROR;
              end else if (WAIT_STATES > 0) begin
                state     <= ST_WAIT;
                hreadyout <= 1'b0;
                hresp     <= OKAY;
                wcnt      <= 4'(WAIT_STATES - 1);
              end else begin
                state     <= ST_DATA;
                hreadyout <= 1'b1;
                hresp     <= OKAY;
              end
            end else begin
              state     <= ST_IDLE;
              hreadyout <= 1'b1;
              hresp     <= OKAY;
              wr_q      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  lvc_ahb_sram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (hclk),
    .we   (mem_we),
    .idx  (idx_q),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_lvc_ahb_sram_slave.sv
// Directed bench: a 32-bit zero-wait slave and a 64-bit three-wait slave side by side.
module tb_lvc_ahb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_sel, a_write, a_rdy;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_trans, a_resp;
  logic [2:0]  a_size;

  logic        b_sel, b_write, b_rdy;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [1:0]  b_trans, b_resp;
  logic [2:0]  b_size;

  lvc_ahb_sram_slave #(.DATA_WIDTH(32), .WAIT_STATES(0)) u_a (
    .hclk(clk), .hresetn(rst_n), .hsel(a_sel), .haddr(a_addr), .htrans(a_trans),
    .hwrite(a_write), .hsize(a_size), .hburst(3'b000), .hprot(4'b0011),
    .hwdata(a_wdata), .hready(a_rdy), .hreadyout(a_rdy), .hresp(a_resp), .hrdata(a_rdata)
  );

  lvc_ahb_sram_slave #(.DATA_WIDTH(64), .WAIT_STATES(3)) u_b (
    .hclk(clk), .hresetn(rst_n), .hsel(b_sel), .haddr(b_addr), .htrans(b_trans),
    .hwrite(b_write), .hsize(b_size), .hburst(3'b001), .hprot(4'b0011),
    .hwdata(b_wdata), .hready(b_rdy), .hreadyout(b_rdy), .hresp(b_resp), .hrdata(b_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic addr_phase(input bit b, input bit wr, input logic [31:0] addr, input logic [2:0] size);
    if (b) begin
      b_sel = 1'b1; b_trans = 2'b10; b_write = wr; b_addr = addr; b_size = size;
    end else begin
      a_sel = 1'b1; a_trans = 2'b10; a_write = wr; a_addr = addr; a_size = size;
    end
  endtask

  task automatic idle_bus(input bit b);
    if (b) begin
      b_sel = 1'b0; b_trans = 2'b00; b_write = 1'b0;
    end else begin
      a_sel = 1'b0; a_trans = 2'b00; a_write = 1'b0;
    end
  endtask

  // Single non-pipelined transfer; reports data, first/last response, data-phase length and low cycles.
  task automatic xfer(input bit b, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata, output logic [63:0] rdata, output logic [1:0] resp0,
                      output logic [1:0] resp, output int cycles, output int lows);
    bit done;
    addr_phase(b, wr, addr, size);
    @(posedge clk); #1;
    idle_bus(b);
    if (b) b_wdata = wdata; else a_wdata = wdata[31:0];
    done = 1'b0; cycles = 0; lows = 0; rdata = '0; resp0 = 2'b00; resp = 2'b00;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) resp0 = b ? b_resp : a_resp;
      if ((b ? b_rdy : a_rdy) == 1'b1) begin
        done  = 1'b1;
        rdata = b ? b_rdata : {32'h0, a_rdata};
        resp  = b ? b_resp : a_resp;
      end else begin
        lows++;
      end
    end
    check("xfer_done", {63'h0, done}, 64'h1);
    @(posedge clk); #1;
  endtask

  logic [63:0] rd;
  logic [1:0]  r0, r1;
  int          cyc, lows;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_bus(1'b0); idle_bus(1'b1);
    a_addr = '0; a_size = 3'd2; a_wdata = '0;
    b_addr = '0; b_size = 3'd3; b_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_a_rdy", {63'h0, a_rdy}, 64'h1);
      check("rst_a_resp", {62'h0, a_resp}, 64'h0);
      check("rst_a_rdata", {32'h0, a_rdata}, 64'h0);
      check("rst_b_rdy", {63'h0, b_rdy}, 64'h1);
      check("rst_b_rdata", b_rdata, 64'h0);
    end
    @(posedge clk); #1;

    // Back-to-back write then read of the same word.
    addr_phase(1'b0, 1'b1, 32'h10, 3'd2);
    @(posedge clk); #1;
    a_wdata = 32'hDEADBEEF;
    addr_phase(1'b0, 1'b0, 32'h10, 3'd2);
    @(negedge clk);
    check("b2b_wr_rdy", {63'h0, a_rdy}, 64'h1);
    check("b2b_wr_rdata_zero", {32'h0, a_rdata}, 64'h0);
    @(posedge clk); #1;
    idle_bus(1'b0);
    @(negedge clk);
    check("b2b_rd_rdy", {63'h0, a_rdy}, 64'h1);
    check("b2b_rd_resp", {62'h0, a_resp}, 64'h0);
    check("b2b_rd_data", {32'h0, a_rdata}, 64'hDEADBEEF);
    @(posedge clk); #1;

    xfer(1'b0, 1'b1, 32'h11, 3'd0, 64'h1122AA44, rd, r0, r1, cyc, lows);
    check("byte_wr_resp", {62'h0, r1}, 64'h0);
    check("byte_wr_cycles", 64'(cyc), 64'd1);
    xfer(1'b0, 1'b0, 32'h10, 3'd2, 64'h0, rd, r0, r1, cyc, lows);
    check("byte_rd_data", rd, 64'hDEADAAEF);

    xfer(1'b0, 1'b1, 32'h0, 3'd2, 64'h01234567, rd, r0, r1, cyc, lows);
    xfer(1'b0, 1'b1, 32'h1000, 3'd2, 64'hFFFFFFFF, rd, r0, r1, cyc, lows);
    check("oob_resp_first", {62'h0, r0}, 64'h1);
    check("oob_resp_last", {62'h0, r1}, 64'h1);
    check("oob_cycles", 64'(cyc), 64'd2);
    check("oob_lows", 64'(lows), 64'd1);
    xfer(1'b0, 1'b0, 32'h0, 3'd2, 64'h0, rd, r0, r1, cyc, lows);
    check("oob_readback", rd, 64'h01234567);
    check("oob_readback_resp", {62'h0, r1}, 64'h0);

    xfer(1'b0, 1'b1, 32'h3, 3'd1, 64'hFFFFFFFF, rd, r0, r1, cyc, lows);
    check("misalign_resp_first", {62'h0, r0}, 64'h1);
    check("misalign_resp_last", {62'h0, r1}, 64'h1);
    check("misalign_cycles", 64'(cyc), 64'd2);
    xfer(1'b0, 1'b0, 32'h0, 3'd2, 64'h0, rd, r0, r1, cyc, lows);
    check("misalign_readback", rd, 64'h01234567);

    xfer(1'b0, 1'b0, 32'h0, 3'd3, 64'h0, rd, r0, r1, cyc, lows);
    check("oversize_resp", {62'h0, r1}, 64'h1);
    check("oversize_rdata_zero", rd, 64'h0);

    // 64-bit slave with three wait states.
    xfer(1'b1, 1'b1, 32'h8, 3'd3, 64'h0123456789ABCDEF, rd, r0, r1, cyc, lows);
    check("b_wr_cycles", 64'(cyc), 64'd4);
    xfer(1'b1, 1'b0, 32'h8, 3'd3, 64'h0, rd, r0, r1, cyc, lows);
    check("b_rd_lows", 64'(lows), 64'd3);
    check("b_rd_cycles", 64'(cyc), 64'd4);
    check("b_rd_data", rd, 64'h0123456789ABCDEF);
    check("b_rd_resp", {62'h0, r1}, 64'h0);

    xfer(1'b1, 1'b1, 32'hE, 3'd1, 64'hBEEF555555555555, rd, r0, r1, cyc, lows);
    xfer(1'b1, 1'b0, 32'h8, 3'd3, 64'h0, rd, r0, r1, cyc, lows);
    check("b_half_rd_data", rd, 64'hBEEF456789ABCDEF);

    // Reset in the middle of a waited write must drop the write.
    addr_phase(1'b1, 1'b1, 32'h8, 3'd3);
    @(posedge clk); #1;
    idle_bus(1'b1);
    b_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    check("mid_wait_rdy", {63'h0, b_rdy}, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rdy", {63'h0, b_rdy}, 64'h1);
    check("async_rst_resp", {62'h0, b_resp}, 64'h0);
    check("async_rst_rdata", b_rdata, 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 32'h8, 3'd3, 64'h0, rd, r0, r1, cyc, lows);
    check("rst_abort_readback", rd, 64'hBEEF456789ABCDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lvc_ahb_sram_slave.md
# lvc_ahb_sram_slave

Parametrised AHB slave that fronts an on-chip SRAM. It supersedes the fixed 32-bit RAM target: data width, depth and wait states are configurable, it handles byte, halfword, word and doubleword lanes, and it returns a two-cycle ERROR for illegal transfers. It sits behind the AHB decoder/mux on the same bus signal set the VIP drives, and it is the DUT target for the lvc_ahb master agent.

## Interface
Parameters
- DATA_WIDTH, default 32: bus data width, legal values 32 or 64; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, default 32: haddr width.
- DEPTH, default 1024: number of DATA_WIDTH words, power of 2; IDXW = $clog2(DEPTH).
- WAIT_STATES, default 0: hreadyout-low cycles inserted per data phase, range 0..15.

Ports
- hclk  in  1  bus clock; all state changes on its rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size, log2 of the byte count.
- hburst  in  3  accepted but ignored; every beat is decoded independently.
- hprot  in  4  ignored.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hready  in  1  bus-level ready (hreadyin).
- hreadyout  out  1  slave ready.
- hresp  out  2  OKAY=00, ERROR=01. RETRY and SPLIT are never generated.
- hrdata  out  DATA_WIDTH  read data.

## Operation
- A transfer is accepted (address phase) on a rising edge where hsel=1, hready=1 and htrans[1]=1. On acceptance the block registers the address, hwrite, hsize and the lane info.
- When htrans is IDLE or BUSY, or hsel=0, nothing is accepted. The following cycle returns OKAY with zero wait states.
- A transfer is illegal if any of the following hold:
  - haddr ≥ DEPTH*BYTES;
  - hsize > $clog2(BYTES);
  - haddr is not aligned to 2^hsize.
- An illegal transfer has no memory side effect.
- Word index = haddr[IDXW+$clog2(BYTES)-1 : $clog2(BYTES)]. Byte lanes are little-endian. The lane mask is (2^(2^hsize))-1, shifted by haddr[$clog2(BYTES)-1:0].
- A write is committed with byte enables on the edge that ends the data phase (hreadyout=1). Lanes outside the mask are preserved.
- A read returns the full word from the registered index while hreadyout=1 in the data phase. hrdata=0 in every other cycle.

FSM states:
- IDLE: hreadyout=1, OKAY.
- WAIT: hreadyout=0, OKAY, wait counter decrementing.
- DATA: hreadyout=1, OKAY; the transfer completes here.
- ERR1: hreadyout=0, ERROR.
- ERR2: hreadyout=1, ERROR.

Transitions:
- Legal accept goes to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), otherwise to DATA.
- Illegal accept goes to ERR1.
- WAIT goes to DATA when the counter reaches 0.
- ERR1 goes to ERR2.
- DATA and ERR2 may accept a new transfer in the same cycle (pipelined). With no new transfer they go to IDLE.

## Timing
- Reset values: hreadyout=1, hresp=00, hrdata=0, state IDLE, wait counter 0.
- Memory contents are not reset.
- Reset asserted mid-transfer aborts immediately. A pending write is discarded.
- Latency: the data phase lasts WAIT_STATES+1 cycles after the address phase. An error costs exactly 2 cycles.
- With WAIT_STATES=0 the block sustains back-to-back transfers at 1 per cycle.
- Write followed by a read to the same word: the write commits on the edge at the end of its data phase. The read data phase starts after that edge, so it returns the new data. No stall and no forwarding path are needed.
- hready=0 while the block is in IDLE/DATA/ERR2 means another slave is stalling. Nothing is accepted and the state holds.
- hsize, haddr and hwdata must be stable per AHB rules. The block does not check this.

## Structure
- lvc_ahb_pkg holds:
  - typedefs htrans_e, hsize_e, hresp_e;
  - state enum ahb_slv_state_e;
  - constants OKAY/ERROR and IDLE/BUSY/NONSEQ/SEQ.
- Sub-module lvc_ahb_sram_mem: a DEPTH×DATA_WIDTH array with a per-byte write enable, a synchronous write and an asynchronous read.
- The top level holds the FSM, the error checks, lane decode and the wait counter.

## Test plan
- After reset, idle bus (htrans=IDLE): hreadyout=1, hresp=00 and hrdata=0 on every cycle.
- DATA_WIDTH=32, WAIT_STATES=0:
  - Write word 0xDEADBEEF at 0x10, then read 0x10 back to back. The read returns 0xDEADBEEF in the cycle after its address phase, with no stall.
  - Then write byte 0xAA (hsize=0) at 0x11 and read 0x10. The read returns 0xDEADAAEF.
- DATA_WIDTH=64, WAIT_STATES=3: read at 0x8. hreadyout is low for exactly 3 cycles, then high with the data. Total cycles measured = 4.
- Write at haddr=DEPTH*BYTES, and separately a halfword at 0x3. Each gives hresp=01 with hreadyout 0 then 1, and a following read shows the memory unchanged.
- Assert hresetn during the WAIT state of a write. Outputs go to their reset values asynchronously and the target word is unchanged on readback.
